// File: rtl/spinner_quad_if.sv
// spinner_quad_if: OSD enable, button requests and quadrature outputs of the spinner
interface spinner_quad_if;
    logic       enable;
    logic       btn_cw;
    logic       btn_ccw;
    logic [1:0] dial;
    logic       step;
    logic       dir;
    modport master (output enable, btn_cw, btn_ccw, input dial, step, dir);
    modport slave (input enable, btn_cw, btn_ccw, output dial, step, dir);
endinterface

// File: rtl/spinner_quad.sv
// spinner_quad: buttons to Gray-coded quadrature dial; define SPINNER_ACCEL_EN for run-length acceleration
module spinner_quad #(
    parameter int unsigned STEP_DIV    = 12000,
    parameter int unsigned ACCEL_STEPS = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    spinner_quad_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN_CW, RUN_CCW} state_t;
    localparam logic [15:0] BASE = 16'(STEP_DIV);
    if (STEP_DIV < 4 || STEP_DIV > 65535) begin : g_bad_step_div
        $error("STEP_DIV must be within 4..65535");
    end
    if (ACCEL_STEPS < 1 || ACCEL_STEPS > 255) begin : g_bad_accel_steps
        $error("ACCEL_STEPS must be within 1..255");
    end
    state_t      state;
    logic [15:0] cnt;
    logic [15:0] period;
    logic        req_cw;
    logic        req_ccw;
    logic        same;
    assign req_cw  = bus.btn_cw & ~bus.btn_ccw;
    assign req_ccw = bus.btn_ccw & ~bus.btn_cw;
    assign same    = (state == RUN_CW && req_cw) || (state == RUN_CCW && req_ccw);
`ifdef SPINNER_ACCEL_EN
    logic [7:0] run_len;
    // Period shrinks as consecutive same-direction steps accumulate
    always_comb period = (run_len < 8'(ACCEL_STEPS)) ? BASE :
                         ({1'b0, run_len} < 9'(2 * ACCEL_STEPS)) ? BASE >> 1 : BASE >> 2;
    // Run-length counts steps in the current direction, saturating, restarting on any new run
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) run_len <= '0;
        else if (!bus.enable || !(req_cw || req_ccw)) run_len <= '0;
        else if (!same) run_len <= 8'd1;
        else if (cnt == '0) run_len <= (run_len == 8'hFF) ? run_len : run_len + 8'd1;
    end
`else
    assign period = BASE;
`endif
    // Run state, step timer, phase and registered outputs move together so step marks each dial change
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.dial <= 2'b11;
            bus.step <= 1'b0;
            bus.dir  <= 1'b1;
        end else if (!bus.enable) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.dial <= 2'b11;
            bus.step <= 1'b0;
        end else if (!(req_cw || req_ccw)) begin
            state    <= IDLE;
            cnt      <= '0;
            bus.step <= 1'b0;
        end else if (same && cnt != '0) begin
            cnt      <= cnt - 16'd1;
            bus.step <= 1'b0;
        end else begin
            state    <= req_cw ? RUN_CW : RUN_CCW;
            cnt      <= (same ? period : BASE) - 16'd1;
            bus.dial <= req_cw ? {~bus.dial[0], bus.dial[1]} : {bus.dial[0], ~bus.dial[1]};
            bus.step <= 1'b1;
            bus.dir  <= req_cw;
        end
    end
endmodule

// File: tb/tb_spinner_quad.sv
// tb_spinner_quad: directed stimulus with a per-cycle behavioural model of the spinner
module tb_spinner_quad;
    localparam int DIV   = 8;
    localparam int ACCEL = 2;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    spinner_quad_if bus ();
    spinner_quad #(.STEP_DIV(DIV), .ACCEL_STEPS(ACCEL)) dut (
        .clk_sys(clk_sys),
        .reset_n(reset_n),
        .bus(bus)
    );
    always #5 clk_sys = ~clk_sys;
    int n_checks = 0;
    int n_fail = 0;
    logic [1:0] gray [4] = '{2'b11, 2'b01, 2'b00, 2'b10};
    int pos, run, since, gap, nrun, req, steps;
    logic m_step, m_dir, ok_now, ok_prev;
    logic [1:0] prev_dial;
    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask
    function automatic int per(input int n);
`ifdef SPINNER_ACCEL_EN
        return n < ACCEL ? DIV : n < 2 * ACCEL ? DIV / 2 : DIV / 4;
`else
        return n >= 0 ? DIV : DIV;
`endif
    endfunction
    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask
    // Model: position in the Gray table, current run, cycles since last step; checked every cycle
    always begin
        @(posedge clk_sys);
        #2;
        req = (bus.btn_cw && !bus.btn_ccw) ? 1 : (bus.btn_ccw && !bus.btn_cw) ? -1 : 0;
        m_step = 1'b0;
        if (!reset_n) begin
            pos = 0; run = 0; m_dir = 1'b1;
        end else if (!bus.enable) begin
            pos = 0; run = 0;
        end else if (req == 0) begin
            run = 0;
        end else if (req != run) begin
            run = req; nrun = 1; since = 0; gap = DIV; m_step = 1'b1;
        end else begin
            since++;
            if (since == gap) begin
                gap = per(nrun); nrun++; since = 0; m_step = 1'b1;
            end
        end
        if (m_step) begin
            pos = (pos + req + 4) % 4;
            m_dir = (req == 1);
        end
        chk("dial", int'(bus.dial), int'(gray[pos]));
        chk("step", int'(bus.step), int'(m_step));
        chk("dir", int'(bus.dir), int'(m_dir));
        ok_now = reset_n && bus.enable;
        if (ok_now && ok_prev) chk("gray_adj", int'($countones(bus.dial ^ prev_dial) <= 1), 1);
        ok_prev = ok_now;
        prev_dial = bus.dial;
    end
    initial begin
        ok_prev = 1'b0;
        bus.enable = 1'b0; bus.btn_cw = 1'b0; bus.btn_ccw = 1'b0;
        cyc(3);
        chk("rst_dial", int'(bus.dial), 3);
        chk("rst_step", int'(bus.step), 0);
        chk("rst_dir", int'(bus.dir), 1);
        reset_n = 1'b1;
        bus.enable = 1'b1;
        cyc(2);
        bus.btn_cw = 1'b1;
        steps = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys);
            if (bus.step) steps++;
            if (i == 0) chk("cw_first_dial", int'(bus.dial), 1);
            if (i == 8) chk("cw_second_dial", int'(bus.dial), 0);
        end
        bus.btn_cw = 1'b0;
`ifdef SPINNER_ACCEL_EN
        chk("cw_step_count", steps, 12);
`else
        chk("cw_step_count", steps, 5);
`endif
        chk("cw_dir", int'(bus.dir), 1);
        bus.enable = 1'b0;
        cyc(1);
        bus.enable = 1'b1;
        bus.btn_cw = 1'b1;
        cyc(1);
        chk("both_start_dial", int'(bus.dial), 1);
        bus.btn_ccw = 1'b1;
        steps = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_sys);
            if (bus.step || bus.dial != 2'b01) steps++;
        end
        chk("both_hold", steps, 0);
        bus.btn_cw = 1'b0; bus.btn_ccw = 1'b0;
        cyc(2);
        bus.btn_cw = 1'b1;
        cyc(1);
        chk("rev_cw_dial", int'(bus.dial), 0);
        cyc(3);
        bus.btn_cw = 1'b0; bus.btn_ccw = 1'b1;
        cyc(1);
        chk("rev_dial", int'(bus.dial), 1);
        chk("rev_dir", int'(bus.dir), 0);
        chk("rev_step", int'(bus.step), 1);
        cyc(7);
        chk("rev_hold_dial", int'(bus.dial), 1);
        cyc(1);
        chk("rev_next_dial", int'(bus.dial), 3);
        bus.btn_ccw = 1'b0;
        cyc(2);
        bus.enable = 1'b0; bus.btn_ccw = 1'b1;
        steps = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_sys);
            if (bus.step || bus.dial != 2'b11) steps++;
        end
        chk("disabled_idle", steps, 0);
        bus.enable = 1'b1;
        cyc(1);
        chk("enable_dial", int'(bus.dial), 2);
        chk("enable_step", int'(bus.step), 1);
        cyc(3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_dial", int'(bus.dial), 3);
        chk("async_rst_dir", int'(bus.dir), 1);
        bus.btn_ccw = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        steps = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_sys);
            if (bus.step || bus.dial != 2'b11) steps++;
        end
        chk("post_rst_quiet", steps, 0);
        bus.btn_ccw = 1'b1;
        cyc(45);
        bus.btn_cw = 1'b1;
        cyc(3);
        bus.btn_ccw = 1'b0;
        cyc(20);
        bus.btn_cw = 1'b0;
        cyc(5);
        for (int i = 0; i < 5; i++) begin
            bus.btn_cw = 1'b1;
            cyc(1);
            bus.btn_cw = 1'b0;
            cyc(1);
        end
        bus.btn_ccw = 1'b1;
        cyc(12);
        bus.btn_ccw = 1'b0;
        cyc(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
